dot_product_sequencer: RTL and testbench
========================================

# dot_product_sequencer

Control block that runs a dot product of arbitrary length (1..MAX_CHUNKS chunks of SIZE_ARRAY lanes) on the fixed-width `baseline` dot-product datapath. It accepts operand chunks on a valid/ready stream and feeds them to the datapath one per cycle. It tracks in-flight chunks through the datapath pipeline, folds the datapath's two partial-sum outputs into a wide accumulator, and returns one signed result per job on a valid/ready output.

## Interface
- IN_SIZE_0, 4, signed width of operand 0 per lane
- IN_SIZE_1, 8, signed width of operand 1 per lane
- SIZE_ARRAY, 8, lanes per chunk (must match datapath)
- PIPE_LAT, 3, datapath latency in clock edges from input applied to dp_out_i valid
- MAX_CHUNKS, 16, maximum chunks per job
- Derived: DP_SIZE = IN_SIZE_0+IN_SIZE_1+8; ACC_SIZE = DP_SIZE+$clog2(MAX_CHUNKS); CNT_W = $clog2(MAX_CHUNKS+1)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  begin job; honoured only in IDLE
- num_chunks_i  in  CNT_W  chunk count, sampled with start_i
- busy_o  out  1  high in any state other than IDLE
- in_valid_i / in_ready_o  in/out  1  operand chunk handshake
- in_0_i  in  SIZE_ARRAY x IN_SIZE_0  chunk operands 0
- in_1_i  in  SIZE_ARRAY x IN_SIZE_1  chunk operands 1
- dp_in_0_o  out  SIZE_ARRAY x IN_SIZE_0  to datapath, registered
- dp_in_1_o  out  SIZE_ARRAY x IN_SIZE_1  to datapath, registered
- dp_out_i  in  2 x DP_SIZE  datapath partial sums; only their sum is meaningful
- result_o  out  ACC_SIZE  signed job result
- result_valid_o / result_ready_i  out/in  1  result handshake

## Operation
- FSM states: IDLE, FEED, DRAIN, RESULT.
- IDLE: on start_i, latch num_chunks_i into `remaining` and clear `acc`.
  - remaining>0: go to FEED.
  - remaining==0: go to RESULT with result 0.
- FEED:
  - in_ready_o = 1.
  - Handshake (in_valid_i & in_ready_o): load dp_in regs with the chunk, push a 1 into the valid pipe, decrement remaining.
  - No handshake: load dp_in regs with zeros and push a 0.
  - Go to DRAIN when the last chunk is accepted.
- DRAIN: in_ready_o = 0; dp_in regs held at zero. Go to RESULT when the valid pipe is empty and the final add has completed.
- RESULT:
  - result_valid_o = 1; result_o = acc, held stable.
  - On result_ready_i, go to IDLE.
- Accumulation:
  - When a valid bit reaches the output of the pipe, sign-extend dp_out_i[0] and dp_out_i[1] to ACC_SIZE and add both into acc.
  - Arithmetic is two's complement. ACC_SIZE cannot overflow for MAX_CHUNKS chunks, so no saturation.
- start_i is ignored outside IDLE; in_valid_i is ignored outside FEED.

## Timing
- Reset values:
  - state IDLE; in_ready_o, busy_o, result_valid_o = 0.
  - result_o, acc, remaining = 0.
  - dp_in_0_o, dp_in_1_o = 0; valid pipe all 0.
- Reset asserted mid-job aborts the job immediately. Any result already in flight is discarded.
- Operand path:
  - A chunk accepted at edge E drives dp_in_*_o from E.
  - Its dp_out_i sum is valid in the cycle after edge E+PIPE_LAT and is added into acc at edge E+PIPE_LAT+1.
- Latency:
  - result_valid_o rises at edge E_last+PIPE_LAT+2, where E_last is the acceptance edge of the last chunk.
  - Zero-chunk job: result_valid_o rises 1 edge after start.
- Throughput: one chunk per cycle with no gaps. Back-to-back jobs need at least one IDLE cycle.
- start_i and result_ready_i in the same cycle in RESULT: complete the handshake and go to IDLE. The start is not taken that cycle.

## Structure
- Package dot_seq_pkg holds:
  - the state enum;
  - width helpers for DP_SIZE, ACC_SIZE and CNT_W;
  - a sign-extend-and-sum function for the two dp_out_i words.
- Sub-module dot_seq_valid_pipe: a PIPE_LAT+1 deep shift register of valid bits with reset, exposing a `valid_out` signal and an `empty` signal.
- The datapath itself is instantiated outside this block. The bench connects it through the dp_* ports.

## Test plan
- Single chunk, all lanes in_0=1 and in_1=1, num_chunks=1 -> result_o=8, result_valid_o at E+PIPE_LAT+2.
- Two chunks, all lanes in_0=-8 and in_1=-128 -> result_o=16384 (extreme-value sign handling).
- num_chunks=0 -> result_valid_o one cycle after start, result_o=0, no dp activity.
- Four chunks with in_valid_i toggling 1,0,0,1,… and result_ready_i held low for 5 cycles -> correct sum; result_o stable while waiting; start_i pulses during the job ignored.
- Reset asserted during FEED after 2 of 4 chunks -> all outputs return to reset values at once; a following 1-chunk job (in_0=3, in_1=-5 on all lanes) gives -120.
- 100 random jobs with random lengths 1..MAX_CHUNKS and random backpressure, against a reference model -> every result matches.

Source files
------------

// File: rtl/dot_seq_pkg.sv
// Shared types and helpers for the dot-product sequencer: FSM state encoding,
// derived-width calculators and the partial-sum fold used by the accumulator.
package dot_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FEED,
    ST_DRAIN,
    ST_RESULT
  } state_t;

  // Working width for the fold helper; the caller truncates to ACC_SIZE.
  localparam int SUM_W = 64;

  function automatic int dp_size(input int in_size_0, input int in_size_1);
    return in_size_0 + in_size_1 + 8;
  endfunction

  function automatic int acc_size(input int dp_w, input int max_chunks);
    return dp_w + $clog2(max_chunks);
  endfunction

  function automatic int cnt_w(input int max_chunks);
    return $clog2(max_chunks + 1);
  endfunction

  function automatic logic [SUM_W-1:0] sext(input logic [SUM_W-1:0] x, input int w);
    logic [SUM_W-1:0] hi;
    logic [SUM_W-1:0] sign;
    hi   = {SUM_W{1'b1}} << w;
    sign = SUM_W'(1) << (w - 1);
    return ((x & sign) != '0) ? (x | hi) : (x & ~hi);
  endfunction

  function automatic logic [SUM_W-1:0] sext_sum(input logic [SUM_W-1:0] a,
                                                input logic [SUM_W-1:0] b,
                                                input int w);
    return sext(a, w) + sext(b, w);
  endfunction

endpackage

// File: rtl/dot_seq_valid_pipe.sv
// Shift register of valid bits that shadows the datapath pipeline so the
// sequencer knows when a partial-sum pair is meaningful and when it has drained.
module dot_seq_valid_pipe
  import dot_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_in,
  output logic valid_out,
  output logic empty
);

  logic [DEPTH-1:0] pipe;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe <= '0;
    end else begin
      pipe <= {pipe[DEPTH-2:0], valid_in};
    end
  end

  assign valid_out = pipe[DEPTH-1];
  assign empty     = ~|pipe;

endmodule

// File: rtl/dot_product_sequencer.sv
// Streams 1..MAX_CHUNKS operand chunks into the external dot-product datapath
// and folds its two partial sums into one signed result per job.
module dot_product_sequencer
  import dot_seq_pkg::*;
#(
  parameter  int IN_SIZE_0  = 4,
  parameter  int IN_SIZE_1  = 8,
  parameter  int SIZE_ARRAY = 8,
  parameter  int PIPE_LAT   = 3,
  parameter  int MAX_CHUNKS = 16,
  localparam int DP_SIZE    = dp_size(IN_SIZE_0, IN_SIZE_1),
  localparam int ACC_SIZE   = acc_size(DP_SIZE, MAX_CHUNKS),
  localparam int CNT_W      = cnt_w(MAX_CHUNKS)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 start_i,
  input  logic [CNT_W-1:0]                     num_chunks_i,
  output logic                                 busy_o,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  input  logic [SIZE_ARRAY-1:0][IN_SIZE_0-1:0] in_0_i,
  input  logic [SIZE_ARRAY-1:0][IN_SIZE_1-1:0] in_1_i,
  output logic [SIZE_ARRAY-1:0][IN_SIZE_0-1:0] dp_in_0_o,
  output logic [SIZE_ARRAY-1:0][IN_SIZE_1-1:0] dp_in_1_o,
  input  logic [1:0][DP_SIZE-1:0]              dp_out_i,
  output logic signed [ACC_SIZE-1:0]           result_o,
  output logic                                 result_valid_o,
  input  logic                                 result_ready_i
);

  state_t                     state;
  state_t                     state_nxt;
  logic [CNT_W-1:0]           remaining;
  logic signed [ACC_SIZE-1:0] acc;
  logic [ACC_SIZE-1:0]        dp_sum;
  logic                       fire;
  logic                       take_start;
  logic                       pipe_out;
  logic                       pipe_empty;

  // Derived from state directly to keep the handshake free of a comb loop.
  assign fire       = in_valid_i & (state == ST_FEED);
  assign take_start = start_i & (state == ST_IDLE);
  assign dp_sum     = ACC_SIZE'(sext_sum(SUM_W'(dp_out_i[0]), SUM_W'(dp_out_i[1]), DP_SIZE));
  assign result_o   = acc;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    busy_o         = 1'b1;
    in_ready_o     = 1'b0;
    result_valid_o = 1'b0;
    case (state)
      ST_IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          state_nxt = (num_chunks_i == '0) ? ST_RESULT : ST_FEED;
        end
      end
      ST_FEED: begin
        in_ready_o = 1'b1;
        if (fire && remaining == CNT_W'(1)) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pipe_empty) begin
          state_nxt = ST_RESULT;
        end
      end
      ST_RESULT: begin
        result_valid_o = 1'b1;
        if (result_ready_i) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Idle cycles feed zeros so the datapath never sees stale operands.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dp_in_0_o <= '0;
      dp_in_1_o <= '0;
      remaining <= '0;
      acc       <= '0;
    end else begin
      dp_in_0_o <= fire ? in_0_i : '0;
      dp_in_1_o <= fire ? in_1_i : '0;
      if (take_start) begin
        remaining <= num_chunks_i;
        acc       <= '0;
      end else begin
        if (fire) begin
          remaining <= remaining - CNT_W'(1);
        end
        if (pipe_out) begin
          acc <= acc + $signed(dp_sum);
        end
      end
    end
  end

  dot_seq_valid_pipe #(
    .DEPTH(PIPE_LAT + 1)
  ) u_valid_pipe (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_in (fire),
    .valid_out(pipe_out),
    .empty    (pipe_empty)
  );

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Bench for dot_product_sequencer: behavioural datapath model, directed jobs and
// random jobs, with a result scoreboard checked by an independent monitor.
module tb_dot_product_sequencer;

  localparam int IN0   = 4;
  localparam int IN1   = 8;
  localparam int LANES = 8;
  localparam int PL    = 3;
  localparam int MAXC  = 16;
  localparam int DP    = 20;
  localparam int ACC   = 24;
  localparam int CW    = 5;
  localparam int K     = 300000;

  logic                        clk_i = 1'b0;
  logic                        rst_i = 1'b1;
  logic                        start_i = 1'b0;
  logic [CW-1:0]               num_chunks_i = '0;
  logic                        busy_o;
  logic                        in_valid_i = 1'b0;
  logic                        in_ready_o;
  logic [LANES-1:0][IN0-1:0]   in_0_i = '0;
  logic [LANES-1:0][IN1-1:0]   in_1_i = '0;
  logic [LANES-1:0][IN0-1:0]   dp_in_0_o;
  logic [LANES-1:0][IN1-1:0]   dp_in_1_o;
  logic [1:0][DP-1:0]          dp_out;
  logic signed [ACC-1:0]       result_o;
  logic                        result_valid_o;
  logic                        result_ready_i = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int exp_q[$];
  int mon_e;

  logic [IN0-1:0] op0 [MAXC][LANES];
  logic [IN1-1:0] op1 [MAXC][LANES];

  logic [PL-1:0][DP-1:0] dps0 = '0;
  logic [PL-1:0][DP-1:0] dps1 = '0;

  dot_product_sequencer dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .num_chunks_i  (num_chunks_i),
    .busy_o        (busy_o),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .in_0_i        (in_0_i),
    .in_1_i        (in_1_i),
    .dp_in_0_o     (dp_in_0_o),
    .dp_in_1_o     (dp_in_1_o),
    .dp_out_i      (dp_out),
    .result_o      (result_o),
    .result_valid_o(result_valid_o),
    .result_ready_i(result_ready_i)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // External datapath: PL register stages, lane halves offset by +/-K.
  function automatic int half_sum(input logic [LANES-1:0][IN0-1:0] a,
                                  input logic [LANES-1:0][IN1-1:0] b,
                                  input int lo);
    int s;
    s = 0;
    for (int l = lo; l < lo + 4; l++) s += int'($signed(a[l])) * int'($signed(b[l]));
    return s;
  endfunction

  always @(posedge clk_i) begin
    dps0 <= {dps0[PL-2:0], DP'(half_sum(dp_in_0_o, dp_in_1_o, 0) + K)};
    dps1 <= {dps1[PL-2:0], DP'(half_sum(dp_in_0_o, dp_in_1_o, 4) - K)};
  end
  assign dp_out[0] = dps0[PL-1];
  assign dp_out[1] = dps1[PL-1];

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    #1;
    if (!rst_i && result_valid_o && result_ready_i) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got %0d with nothing expected", result_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("result", longint'(result_o), longint'(mon_e));
      end
    end
  end

  function automatic int model_job(input int n);
    int s;
    s = 0;
    for (int k = 0; k < n; k++)
      for (int l = 0; l < LANES; l++)
        s += int'($signed(op0[k][l])) * int'($signed(op1[k][l]));
    return s;
  endfunction

  task automatic drive_chunk(input int idx);
    for (int l = 0; l < LANES; l++) begin
      in_0_i[l] = op0[idx % MAXC][l];
      in_1_i[l] = op1[idx % MAXC][l];
    end
  endtask

  // vmode: 0 = always valid, 1 = 1,0,0 pattern, 2 = random gaps.
  task automatic run_job(input int n, input int exp, input int vmode, input int hold,
                         input bit noise);
    int fed, i, e_last, t, exp_edge;
    bit acc_now;
    exp_q.push_back(exp);
    @(negedge clk_i);
    start_i = 1'b1;
    num_chunks_i = CW'(n);
    @(negedge clk_i);
    start_i = 1'b0;
    num_chunks_i = '0;
    e_last = cyc;
    fed = 0;
    i = 0;
    while (fed < n && i < 400) begin
      case (vmode)
        0:       in_valid_i = 1'b1;
        1:       in_valid_i = (i % 3 == 0);
        default: in_valid_i = ($urandom_range(0, 2) != 0);
      endcase
      drive_chunk(in_valid_i ? fed : fed + 1);
      if (noise) begin
        start_i = i[0];
        num_chunks_i = CW'(7);
      end
      #1;
      if (in_valid_i) check("in_ready_feed", longint'(in_ready_o), 1);
      acc_now = in_valid_i && in_ready_o;
      @(negedge clk_i);
      if (acc_now) begin
        fed++;
        e_last = cyc;
      end
      i++;
    end
    in_valid_i = 1'b0;
    if (i >= 400) check("feed_timeout", longint'(fed), longint'(n));
    exp_edge = (n == 0) ? e_last : e_last + PL + 2;
    t = 0;
    while (!result_valid_o && t < 60) begin
      @(negedge clk_i);
      t++;
    end
    if (!result_valid_o) begin
      check("result_timeout", longint'(result_valid_o), 1);
    end else begin
      check("latency", longint'(cyc), longint'(exp_edge));
      check("dp_in_0_idle", longint'(dp_in_0_o), 0);
      check("dp_in_1_idle", longint'(dp_in_1_o), 0);
      check("in_ready_result", longint'(in_ready_o), 0);
      check("busy_result", longint'(busy_o), 1);
    end
    for (int h = 0; h < hold; h++) begin
      start_i = noise;
      #1;
      check("result_hold", longint'(result_o), longint'(exp));
      check("valid_hold", longint'(result_valid_o), 1);
      @(negedge clk_i);
    end
    result_ready_i = 1'b1;
    start_i = noise;
    @(negedge clk_i);
    result_ready_i = 1'b0;
    start_i = 1'b0;
    num_chunks_i = '0;
    #1;
    check("idle_after_result", longint'(busy_o), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk_i);
    #1;
    check("rst_busy", longint'(busy_o), 0);
    check("rst_in_ready", longint'(in_ready_o), 0);
    check("rst_result_valid", longint'(result_valid_o), 0);
    check("rst_result", longint'(result_o), 0);
    check("rst_dp_in_0", longint'(dp_in_0_o), 0);
    check("rst_dp_in_1", longint'(dp_in_1_o), 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    for (int l = 0; l < LANES; l++) begin
      op0[0][l] = 4'd1;
      op1[0][l] = 8'd1;
    end
    run_job(1, 8, 0, 0, 1'b0);

    for (int k = 0; k < 2; k++)
      for (int l = 0; l < LANES; l++) begin
        op0[k][l] = 4'h8;
        op1[k][l] = 8'h80;
      end
    run_job(2, 16384, 0, 1, 1'b0);

    run_job(0, 0, 0, 2, 1'b0);

    for (int k = 0; k < 4; k++)
      for (int l = 0; l < LANES; l++) begin
        op0[k][l] = 4'(k + 1);
        op1[k][l] = 8'(10 * l - 30);
      end
    run_job(4, 400, 1, 5, 1'b1);

    // Abort a 4-chunk job after two chunks have been accepted.
    for (int k = 0; k < 4; k++)
      for (int l = 0; l < LANES; l++) begin
        op0[k][l] = 4'd2;
        op1[k][l] = 8'd7;
      end
    @(negedge clk_i);
    start_i = 1'b1;
    num_chunks_i = CW'(4);
    @(negedge clk_i);
    start_i = 1'b0;
    num_chunks_i = '0;
    in_valid_i = 1'b1;
    drive_chunk(0);
    @(negedge clk_i);
    drive_chunk(1);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check("abort_busy", longint'(busy_o), 0);
    check("abort_in_ready", longint'(in_ready_o), 0);
    check("abort_result_valid", longint'(result_valid_o), 0);
    check("abort_result", longint'(result_o), 0);
    check("abort_dp_in_0", longint'(dp_in_0_o), 0);
    check("abort_dp_in_1", longint'(dp_in_1_o), 0);
    in_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    for (int l = 0; l < LANES; l++) begin
      op0[0][l] = 4'd3;
      op1[0][l] = 8'hFB;
    end
    run_job(1, -120, 0, 0, 1'b0);

    for (int j = 0; j < 100; j++) begin
      int n;
      n = $urandom_range(1, MAXC);
      for (int k = 0; k < MAXC; k++)
        for (int l = 0; l < LANES; l++) begin
          op0[k][l] = 4'($urandom_range(0, 15));
          op1[k][l] = 8'($urandom_range(0, 255));
        end
      run_job(n, model_job(n), 2, $urandom_range(0, 3), 1'b0);
    end

    repeat (2) @(negedge clk_i);
    check("scoreboard_drained", longint'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
